dcache_2way_wb: RTL and testbench

Parametrised successor to the direct-mapped L1 data cache: 2-way set-associative, write-back, write-allocate, with per-set LRU replacement, per-byte write enables and a whole-cache flush. It sits between the pipeline MEM stage (p1_* interface) and the line-wide data memory (mem_* interface). Tag, valid, dirty and data arrays are internal registers, so the block needs no separate SRAM models.

---
 rtl/dcache_2way_wb.sv | 181 ++++++++++++++++++
 tb/tb_dcache_2way_wb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_wb.sv
// rtl/dcache_2way_wb.sv - 2-way set-associative write-back, write-allocate L1 data cache
// Per-set LRU replacement, byte-enable writes and a whole-cache flush walker.
module dcache_2way_wb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   p1_addr_i,
    input  logic [DATA_W-1:0]   p1_data_i,
    input  logic [DATA_W/8-1:0] p1_be_i,
    input  logic                p1_MemRead_i,
    input  logic                p1_MemWrite_i,
    output logic [DATA_W-1:0]   p1_data_o,
    output logic                p1_stall_o,
    input  logic                flush_i,
    output logic                flush_busy_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_enable_o,
    output logic                mem_write_o
);
    localparam int OFF_W    = $clog2(LINE_W / 8);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
    localparam int BE_W     = DATA_W / 8;
    localparam int WORD_SEL = OFF_W - $clog2(BE_W);
    localparam int LSB_W    = $clog2(LINE_W);

    typedef enum logic [2:0] {
        IDLE, MISS, WRITEBACK, REFILL, REFILLOK, FLUSH, FLUSH_WB
    } state_t;

    state_t              state_q;
    logic [LINE_W-1:0]   data_q  [2][SETS];
    logic [TAG_W-1:0]    tag_q   [2][SETS];
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;
    logic                victim_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [IDX_W-1:0]    miss_idx_q;
    logic [IDX_W:0]      flush_cnt_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [WORD_SEL-1:0] word;
    logic [LSB_W-1:0]    word_lsb;
    logic                req, hit0, hit1, hit, hit_way, victim;
    logic [LINE_W-1:0]   hit_line;
    logic [DATA_W-1:0]   wr_word;
    logic [IDX_W-1:0]    fl_set;
    logic                fl_way, fl_last;
    logic                unused_addr_lsb;

    assign idx      = p1_addr_i[OFF_W +: IDX_W];
    assign tag      = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign word     = p1_addr_i[OFF_W-1 -: WORD_SEL];
    assign word_lsb = {word, {$clog2(DATA_W){1'b0}}};
    assign unused_addr_lsb = ^p1_addr_i[OFF_W-WORD_SEL-1:0];

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = data_q[hit_way][idx];
    assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

    assign fl_set   = flush_cnt_q[IDX_W:1];
    assign fl_way   = flush_cnt_q[0];
    assign fl_last  = (flush_cnt_q == '1);

    assign flush_busy_o = (state_q == FLUSH) || (state_q == FLUSH_WB);
    assign p1_stall_o   = req & (~hit | (state_q != IDLE) | flush_busy_o);
    assign p1_data_o    = (p1_MemRead_i & ~p1_MemWrite_i & hit) ? hit_line[word_lsb +: DATA_W] : '0;
    assign mem_enable_o = (state_q == WRITEBACK) || (state_q == REFILL) || (state_q == FLUSH_WB);
    assign mem_write_o  = (state_q == WRITEBACK) || (state_q == FLUSH_WB);

    always_comb begin
        wr_word = hit_line[word_lsb +: DATA_W];
        for (int b = 0; b < BE_W; b++) begin
            if (p1_be_i[b]) wr_word[8*b +: 8] = p1_data_i[8*b +: 8];
        end
    end

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state_q)
            WRITEBACK: begin
                mem_addr_o = {tag_q[victim_q][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
                mem_data_o = data_q[victim_q][miss_idx_q];
            end
            REFILL:    mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
            FLUSH_WB: begin
                mem_addr_o = {tag_q[fl_way][fl_set], fl_set, {OFF_W{1'b0}}};
                mem_data_o = data_q[fl_way][fl_set];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            dirty_q[0]  <= '0;
            dirty_q[1]  <= '0;
            lru_q       <= '0;
            victim_q    <= 1'b0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        victim_q   <= victim;
                        miss_tag_q <= tag;
                        miss_idx_q <= idx;
                        state_q    <= MISS;
                    end else begin
                        if (req) begin
                            // LRU points at the way to evict next: the one not just used
                            lru_q[idx] <= ~hit_way;
                            if (p1_MemWrite_i) begin
                                data_q[hit_way][idx][word_lsb +: DATA_W] <= wr_word;
                                dirty_q[hit_way][idx] <= 1'b1;
                            end
                        end
                        if (flush_i) begin
                            flush_cnt_q <= '0;
                            state_q     <= FLUSH;
                        end
                    end
                end
                MISS: begin
                    if (valid_q[victim_q][miss_idx_q] && dirty_q[victim_q][miss_idx_q])
                        state_q <= WRITEBACK;
                    else
                        state_q <= REFILL;
                end
                WRITEBACK: begin
                    if (mem_ack_i) state_q <= REFILL;
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        data_q[victim_q][miss_idx_q]  <= mem_data_i;
                        tag_q[victim_q][miss_idx_q]   <= miss_tag_q;
                        valid_q[victim_q][miss_idx_q] <= 1'b1;
                        dirty_q[victim_q][miss_idx_q] <= 1'b0;
                        state_q <= REFILLOK;
                    end
                end
                REFILLOK: state_q <= IDLE;
                FLUSH, FLUSH_WB: begin
                    if (state_q == FLUSH && valid_q[fl_way][fl_set] && dirty_q[fl_way][fl_set]) begin
                        state_q <= FLUSH_WB;
                    end else if (state_q == FLUSH || mem_ack_i) begin
                        valid_q[fl_way][fl_set] <= 1'b0;
                        dirty_q[fl_way][fl_set] <= 1'b0;
                        flush_cnt_q <= flush_cnt_q + (IDX_W+1)'(1);
                        if (fl_last) begin
                            lru_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb/tb_dcache_2way_wb.sv - self-checking bench for dcache_2way_wb
// Vector table plus scoreboards for read data and memory transactions; shadow word model.
module tb_dcache_2way_wb;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic [3:0]   p1_be_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         flush_i = 1'b0;
    logic         flush_busy_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    dcache_2way_wb #(.ADDR_W(32), .DATA_W(32), .LINE_W(256), .SETS(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_be_i(p1_be_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
        .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        miss;
        logic        wb;
        logic [31:0] wb_addr;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    txn_t txn_log[$];
    txn_t exp_txn[$];
    logic [31:0] exp_rd_q[$];
    logic [255:0] mem [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    vec_t vecs [21];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0)  return 32'hA5A5_A5A5;
        if (a == 32'h44) return 32'hFFFF_FFFF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(a + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic logic [255:0] sh_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = sh_word(a + 32'(4*i));
        return l;
    endfunction

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic miss, input logic wb, input logic [31:0] wb_addr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.miss = miss; v.wb = wb; v.wb_addr = wb_addr;
        return v;
    endfunction

    // Line-wide memory: acks after ack_delay cycles of a held request
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            if (rst_i || !mem_enable_o) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt  = 0;
                mem_ack_i = 1'b1;
                if (mem_write_o) begin
                    mem[mem_addr_o] = mem_data_o;
                    txn_log.push_back(txn_t'{1'b1, mem_addr_o, mem_data_o});
                end else begin
                    mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : init_line(mem_addr_o);
                    txn_log.push_back(txn_t'{1'b0, mem_addr_o, 256'h0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_txns(input string tag);
        txn_t e, a;
        chk({tag, "_ntxn"}, 256'(txn_log.size()), 256'(exp_txn.size()));
        while (exp_txn.size() > 0 && txn_log.size() > 0) begin
            e = exp_txn.pop_front();
            a = txn_log.pop_front();
            chk({tag, "_txn_wr"}, 256'(a.wr), 256'(e.wr));
            chk({tag, "_txn_addr"}, 256'(a.addr), 256'(e.addr));
            if (e.wr) chk({tag, "_txn_data"}, a.data, e.data);
        end
        txn_log.delete();
        exp_txn.delete();
    endtask

    task automatic do_vec(input int n);
        vec_t v;
        logic [31:0] exp_rd, merged;
        int cyc;
        v = vecs[n];
        exp_rd = sh_word(v.addr);
        merged = exp_rd;
        for (int b = 0; b < 4; b++) if (v.be[b]) merged[8*b +: 8] = v.wdata[8*b +: 8];
        if (v.miss) begin
            if (v.wb) exp_txn.push_back(txn_t'{1'b1, v.wb_addr, sh_line(v.wb_addr)});
            exp_txn.push_back(txn_t'{1'b0, {v.addr[31:5], 5'b0}, 256'h0});
        end
        if (v.rd && !v.wr) exp_rd_q.push_back(exp_rd);
        p1_addr_i = v.addr; p1_data_i = v.wdata; p1_be_i = v.be;
        p1_MemRead_i = v.rd; p1_MemWrite_i = v.wr;
        @(negedge clk_i);
        chk($sformatf("v%0d_stall_first", n), 256'(p1_stall_o), 256'(v.miss));
        cyc = 0;
        while (p1_stall_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        chk($sformatf("v%0d_stall_timeout", n), 256'(p1_stall_o), 256'(0));
        if (v.rd && !v.wr) chk($sformatf("v%0d_rdata", n), 256'(p1_data_o), 256'(exp_rd_q.pop_front()));
        @(posedge clk_i); #1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        if (v.wr) shadow[v.addr] = merged;
        check_txns($sformatf("v%0d", n));
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic prev_en, prev_wr;
        logic [31:0] prev_addr;
        logic [255:0] prev_data;
        int cyc, rises, unstable, stall_cyc;

        vecs[0]  = mkv(1, 0, 32'h000, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[1]  = mkv(1, 0, 32'h000, 32'h0,         4'h0, 0, 0, 32'h0);
        vecs[2]  = mkv(1, 0, 32'h044, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[3]  = mkv(0, 1, 32'h044, 32'h1234_5678, 4'h3, 0, 0, 32'h0);
        vecs[4]  = mkv(1, 0, 32'h044, 32'h0,         4'h0, 0, 0, 32'h0);
        vecs[5]  = mkv(0, 1, 32'h400, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0);
        vecs[6]  = mkv(1, 0, 32'h000, 32'h0,         4'h0, 0, 0, 32'h0);
        vecs[7]  = mkv(1, 0, 32'h800, 32'h0,         4'h0, 1, 1, 32'h400);
        vecs[8]  = mkv(1, 0, 32'h000, 32'h0,         4'h0, 0, 0, 32'h0);
        vecs[9]  = mkv(1, 0, 32'h400, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[10] = mkv(1, 1, 32'h004, 32'h0BAD_F00D, 4'hF, 0, 0, 32'h0);
        vecs[11] = mkv(1, 0, 32'h004, 32'h0,         4'h0, 0, 0, 32'h0);
        vecs[12] = mkv(0, 1, 32'h0A0, 32'h1111_2222, 4'hF, 1, 0, 32'h0);
        vecs[13] = mkv(0, 1, 32'h4A4, 32'h3333_4444, 4'hF, 1, 0, 32'h0);
        vecs[14] = mkv(1, 0, 32'h000, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[15] = mkv(1, 0, 32'h0A0, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[16] = mkv(1, 0, 32'h060, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[17] = mkv(0, 1, 32'h460, 32'hCAFE_0001, 4'hF, 1, 0, 32'h0);
        vecs[18] = mkv(0, 1, 32'h220, 32'h1357_2468, 4'hC, 1, 0, 32'h0);
        vecs[19] = mkv(1, 0, 32'h460, 32'h0,         4'h0, 1, 0, 32'h0);
        vecs[20] = mkv(1, 0, 32'h220, 32'h0,         4'h0, 1, 0, 32'h0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_flush_busy", 256'(flush_busy_o), 256'(0));
        chk("rst_stall", 256'(p1_stall_o), 256'(0));
        chk("rst_rdata", 256'(p1_data_o), 256'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int n = 0; n <= 13; n++) do_vec(n);

        // Dirty victim 0x0A0 evicted by 0x8A0 with slow memory
        ack_delay = 10;
        exp_rd = sh_word(32'h8A0);
        exp_txn.push_back(txn_t'{1'b1, 32'h0A0, sh_line(32'h0A0)});
        exp_txn.push_back(txn_t'{1'b0, 32'h8A0, 256'h0});
        p1_addr_i = 32'h8A0; p1_MemRead_i = 1'b1;
        prev_en = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_data = '0;
        rises = 0; unstable = 0; stall_cyc = 0; cyc = 0;
        @(negedge clk_i);
        while (p1_stall_o && cyc < 200) begin
            stall_cyc++;
            if (mem_enable_o && !prev_en) rises++;
            if (mem_enable_o && prev_en && mem_write_o == prev_wr &&
                (mem_addr_o !== prev_addr || (mem_write_o && mem_data_o !== prev_data))) unstable++;
            prev_en = mem_enable_o; prev_wr = mem_write_o;
            prev_addr = mem_addr_o; prev_data = mem_data_o;
            @(negedge clk_i);
            cyc++;
        end
        chk("dly_stall_held", 256'(stall_cyc >= 22), 256'(1));
        chk("dly_enable_rises", 256'(rises), 256'(1));
        chk("dly_unstable", 256'(unstable), 256'(0));
        chk("dly_rdata", 256'(p1_data_o), 256'(exp_rd));
        @(posedge clk_i); #1;
        p1_MemRead_i = 1'b0;
        check_txns("dly");

        // Reset in the middle of a refill of 0xC00
        ack_delay = 30;
        p1_addr_i = 32'hC00; p1_MemRead_i = 1'b1;
        cyc = 0;
        @(negedge clk_i);
        while (!(mem_enable_o && !mem_write_o) && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("rst_mid_in_refill", 256'(mem_enable_o & ~mem_write_o), 256'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b1; p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_enable_pre", 256'(mem_enable_o), 256'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_enable", 256'(mem_enable_o), 256'(0));
        @(posedge clk_i); #1;
        ack_delay = 0;
        check_txns("rst_mid");

        for (int n = 14; n <= 18; n++) do_vec(n);

        // Flush: dirty set 3 way1 (0x460) then set 17 way0 (0x220)
        exp_txn.push_back(txn_t'{1'b1, 32'h460, sh_line(32'h460)});
        exp_txn.push_back(txn_t'{1'b1, 32'h220, sh_line(32'h220)});
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_busy_start", 256'(flush_busy_o), 256'(1));
        @(posedge clk_i); #1;
        flush_i = 1'b1; p1_addr_i = 32'h0A0; p1_MemRead_i = 1'b1;
        @(negedge clk_i);
        chk("flush_req_stall", 256'(p1_stall_o), 256'(1));
        @(posedge clk_i); #1;
        flush_i = 1'b0; p1_MemRead_i = 1'b0;
        cyc = 0;
        @(negedge clk_i);
        while (flush_busy_o && cyc < 500) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("flush_done", 256'(flush_busy_o), 256'(0));
        repeat (3) @(negedge clk_i);
        chk("flush_no_restart", 256'(flush_busy_o), 256'(0));
        chk("flush_idle_enable", 256'(mem_enable_o), 256'(0));
        @(posedge clk_i); #1;
        check_txns("flush");

        for (int n = 19; n <= 20; n++) do_vec(n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
